// File: rtl/trig_monitor.sv
// trig_monitor: watches the rare-event nets (r1 & r2) and the trigger line of a
// hardware-trojan candidate. It counts rare events per observation window and
// walks IDLE -> WATCH -> SUSPECT -> ALARM. While the block is in ALARM (and on
// the cycle it enters ALARM), the AES ciphertext output is forced to zero and
// its valid flag is dropped.
//
// Parameters:
//   WINDOW      observation window length in cycles (2..65536)
//   SUSPECT_TH  rare-event count that enters SUSPECT
//   ALARM_TH    rare-event count that enters ALARM (SUSPECT_TH < ALARM_TH <= 255)
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   r1, r2          rare-event conditions; a rare event is r1 & r2 in one cycle
//   trigger         trigger line; when it is 1, the next state is ALARM
//   ct_in/_valid_in ciphertext from the AES core
//   alarm_clr       software clear; leaves ALARM only while trigger is 0
//   ct_out/_valid   gated ciphertext, one-cycle latency
//   alarm           sticky alarm flag (state == ALARM)
//   event_count     rare events in the current window, saturating at 255
//   state           IDLE=0, WATCH=1, SUSPECT=2, ALARM=3
module trig_monitor #(
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned SUSPECT_TH = 4,
  parameter int unsigned ALARM_TH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r1,
  input  logic         r2,
  input  logic         trigger,
  input  logic [127:0] ct_in,
  input  logic         ct_valid_in,
  input  logic         alarm_clr,
  output logic [127:0] ct_out,
  output logic         ct_valid_out,
  output logic         alarm,
  output logic [7:0]   event_count,
  output logic [1:0]   state
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SUS_TH_C  = CNT_W'(SUSPECT_TH);
  localparam logic [CNT_W-1:0] ALM_TH_C  = CNT_W'(ALARM_TH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    SUSPECT = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIN_W-1:0] win_q, win_d;
  logic             rare, wrap;

  assign rare        = r1 & r2;
  assign wrap        = (win_q == WIN_LAST);
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign state       = state_q;
  assign event_count = cnt_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      alarm   <= (state_d == ALARM);
    end
  end

  // Next state and counter updates. Outside ALARM the state is a pure function
  // of the updated count, so a window wrap demotes SUSPECT/WATCH automatically.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = wrap ? '0 : win_q + WIN_W'(1);
    if (state_q == ALARM) begin
      if (alarm_clr && !trigger) begin
        state_d = IDLE;
        cnt_d   = '0;
        win_d   = '0;
      end else if (rare) begin
        cnt_d = cnt_inc;
      end
    end else begin
      if (wrap) begin
        cnt_d = rare ? CNT_W'(1) : '0;
      end else if (rare) begin
        cnt_d = cnt_inc;
      end
      if (trigger || (cnt_d >= ALM_TH_C)) begin
        state_d = ALARM;
      end else if (cnt_d >= SUS_TH_C) begin
        state_d = SUSPECT;
      end else if (cnt_d != '0) begin
        state_d = WATCH;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Ciphertext gate: a block that coincides with the alarm firing is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_out       <= '0;
      ct_valid_out <= 1'b0;
    end else if (state_d == ALARM) begin
      ct_out       <= '0;
      ct_valid_out <= 1'b0;
    end else begin
      ct_valid_out <= ct_valid_in;
      if (ct_valid_in) begin
        ct_out <= ct_in;
      end
    end
  end

endmodule

// File: tb/tb_trig_monitor.sv
// Testbench for trig_monitor. Instance a uses the default parameters, and
// instance b uses WINDOW=8. Both instances share all inputs, and each check
// selects the instance it examines.
module tb_trig_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r1 = 1'b0, r2 = 1'b0, trigger = 1'b0;
  logic         ct_valid_in = 1'b0, alarm_clr = 1'b0;
  logic [127:0] ct_in = '0;

  logic [127:0] a_ct_out, b_ct_out;
  logic         a_ct_valid_out, b_ct_valid_out, a_alarm, b_alarm;
  logic [7:0]   a_event_count, b_event_count;
  logic [1:0]   a_state, b_state;

  always #5 clk = ~clk;

  trig_monitor dut_a (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .trigger(trigger),
    .ct_in(ct_in), .ct_valid_in(ct_valid_in), .alarm_clr(alarm_clr),
    .ct_out(a_ct_out), .ct_valid_out(a_ct_valid_out), .alarm(a_alarm),
    .event_count(a_event_count), .state(a_state)
  );

  trig_monitor #(.WINDOW(8)) dut_b (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .trigger(trigger),
    .ct_in(ct_in), .ct_valid_in(ct_valid_in), .alarm_clr(alarm_clr),
    .ct_out(b_ct_out), .ct_valid_out(b_ct_valid_out), .alarm(b_alarm),
    .event_count(b_event_count), .state(b_state)
  );

  typedef struct {
    bit           rs;
    bit           sel;
    logic         a, b, t, c, v;
    logic [127:0] d;
    logic [1:0]   st;
    logic [7:0]   cnt;
    string        name;
  } vec_t;

  typedef struct {
    bit           sel;
    logic [1:0]   st;
    logic [7:0]   cnt;
    logic         alm;
    logic         vld;
    logic [127:0] ct;
    string        name;
  } exp_t;

  localparam logic [127:0] P  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] G  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] X1 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] X2 = 128'h55555555666666667777777788888888;
  localparam logic [127:0] X3 = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
  localparam logic [127:0] X4 = 128'hcafef00dcafef00dcafef00dcafef00d;

  vec_t         tbl[$];
  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [127:0] last_ct = '0;
  bit           sel = 1'b0;

  function automatic void add(bit rs, bit s, logic a, logic b, logic t, logic c,
                              logic v, logic [127:0] d, logic [1:0] st,
                              logic [7:0] cnt, string nm);
    vec_t x;
    x.rs = rs; x.sel = s; x.a = a; x.b = b; x.t = t; x.c = c; x.v = v;
    x.d = d; x.st = st; x.cnt = cnt; x.name = nm;
    tbl.push_back(x);
  endfunction

  // Expected outputs after the next edge. When the state is ALARM, the block is
  // gated. Otherwise ct_out follows valid blocks and holds its value when no
  // valid block arrives.
  task automatic push_exp(logic [1:0] st, logic [7:0] cnt, logic v,
                          logic [127:0] d, string nm);
    exp_t e;
    e.sel = sel; e.st = st; e.cnt = cnt; e.alm = (st == 2'd3); e.name = nm;
    if (st == 2'd3) begin
      e.vld = 1'b0;
      e.ct  = '0;
    end else begin
      e.vld = v;
      e.ct  = v ? d : last_ct;
    end
    last_ct = e.ct;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t         e;
    logic [1:0]   st;
    logic [7:0]   cnt;
    logic         alm, vld;
    logic [127:0] ct;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got no expectation, want one");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      st = b_state; cnt = b_event_count; alm = b_alarm; vld = b_ct_valid_out; ct = b_ct_out;
    end else begin
      st = a_state; cnt = a_event_count; alm = a_alarm; vld = a_ct_valid_out; ct = a_ct_out;
    end
    if ({st, cnt, alm, vld, ct} !== {e.st, e.cnt, e.alm, e.vld, e.ct}) begin
      fails++;
      $display("FAIL %s: got state=%0d count=%0d alarm=%0b valid=%0b ct=%h, want state=%0d count=%0d alarm=%0b valid=%0b ct=%h",
               e.name, st, cnt, alm, vld, ct, e.st, e.cnt, e.alm, e.vld, e.ct);
    end
  endtask

  task automatic step(vec_t v);
    r1 = v.a; r2 = v.b; trigger = v.t; alarm_clr = v.c;
    ct_valid_in = v.v; ct_in = v.d;
    push_exp(v.st, v.cnt, v.v, v.d, v.name);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Assert reset between edges, check the outputs asynchronously, and release
  // reset on a falling edge so that the next rising edge is the first active edge.
  task automatic do_reset(bit s, string nm);
    sel = s;
    rst = 1'b0;
    r1 = 1'b0; r2 = 1'b0; trigger = 1'b0; alarm_clr = 1'b0;
    ct_valid_in = 1'b0; ct_in = '0;
    #1;
    last_ct = '0;
    push_exp(2'd0, 8'd0, 1'b0, '0, nm);
    check_pop();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // Default instance: pass-through, threshold walk, clear, and trigger override.
    add(1, 0, 0, 0, 0, 0, 1, P,  0, 0, "pass_through");
    add(0, 0, 0, 0, 0, 0, 0, G,  0, 0, "hold_no_valid");
    add(0, 0, 1, 0, 0, 0, 0, G,  0, 0, "r1_only");
    add(0, 0, 0, 1, 0, 0, 0, G,  0, 0, "r2_only");
    add(0, 0, 1, 1, 0, 0, 1, X1, 1, 1, "event1_watch");
    add(0, 0, 1, 1, 0, 0, 0, G,  1, 2, "event2");
    add(0, 0, 1, 1, 0, 0, 0, G,  1, 3, "event3");
    add(0, 0, 1, 1, 0, 0, 0, G,  2, 4, "event4_suspect");
    for (int i = 5; i <= 15; i++)
      add(0, 0, 1, 1, 0, 0, 0, G, 2, 8'(i), "walk_suspect");
    add(0, 0, 1, 1, 0, 0, 1, X2, 3, 16, "alarm_threshold");
    add(0, 0, 1, 1, 0, 0, 0, G,  3, 17, "alarm_count_continues");
    add(0, 0, 0, 0, 1, 1, 0, G,  3, 17, "clr_with_trigger");
    add(0, 0, 0, 0, 0, 1, 1, X3, 0, 0,  "clr_exit");
    add(0, 0, 0, 0, 1, 0, 1, X4, 3, 0,  "trigger_override");
    add(0, 0, 0, 0, 0, 0, 1, X1, 3, 0,  "alarm_sticky");
    add(0, 0, 0, 0, 1, 1, 0, G,  3, 0,  "trig_clr_blocked");
    add(0, 0, 0, 0, 0, 1, 0, G,  0, 0,  "trig_clr_exit");
    add(0, 0, 1, 1, 0, 1, 1, X2, 1, 1,  "clr_outside_alarm");
    // WINDOW=8 instance: window decay, window clear on exit, no decay in ALARM.
    add(1, 1, 1, 1, 0, 0, 0, G, 1, 1, "w_event1");
    add(0, 1, 1, 1, 0, 0, 0, G, 1, 2, "w_event2");
    add(0, 1, 1, 1, 0, 0, 0, G, 1, 3, "w_event3");
    for (int i = 4; i <= 7; i++)
      add(0, 1, 0, 0, 0, 0, 0, G, 1, 3, "w_watch_until_wrap");
    add(0, 1, 0, 0, 0, 0, 0, G, 0, 0, "w_wrap_decay");
    for (int i = 9; i <= 15; i++)
      add(0, 1, 0, 0, 0, 0, 0, G, 0, 0, "w_idle_quiet");
    add(0, 1, 1, 1, 0, 0, 0, G, 1, 1, "w_event_on_wrap");
    add(0, 1, 0, 0, 0, 0, 0, G, 1, 1, "w_after_wrap");
    add(0, 1, 0, 0, 1, 0, 0, G, 3, 1, "w_trigger");
    add(0, 1, 0, 0, 0, 1, 0, G, 0, 0, "w_clr");
    add(0, 1, 1, 1, 0, 0, 0, G, 1, 1, "w_event_after_clr");
    for (int i = 21; i <= 26; i++)
      add(0, 1, 0, 0, 0, 0, 0, G, 1, 1, "w_window_restarted");
    add(0, 1, 0, 0, 0, 0, 0, G, 0, 0, "w_wrap_after_clr");
    add(0, 1, 1, 1, 0, 0, 0, G, 1, 1, "w_event_again");
    add(0, 1, 0, 0, 1, 0, 0, G, 3, 1, "w_trigger2");
    for (int i = 30; i <= 37; i++)
      add(0, 1, 0, 0, 0, 0, 0, G, 3, 1, "w_alarm_ignores_wrap");
    add(0, 1, 0, 0, 0, 1, 0, G, 0, 0, "w_clr2");

    #2;
    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset(tbl[i].sel, "reset_state");
      step(tbl[i]);
    end

    // Saturation: rare events held for 300 cycles across a window wrap.
    do_reset(1'b0, "sat_reset");
    for (int i = 1; i <= 300; i++) begin
      v.rs = 0; v.sel = 0; v.a = 1; v.b = 1; v.t = 0; v.c = 0; v.v = 0; v.d = G;
      v.cnt  = (i > 255) ? 8'd255 : 8'(i);
      v.st   = (i >= 16) ? 2'd3 : (i >= 4) ? 2'd2 : 2'd1;
      v.name = "saturate";
      step(v);
    end

    // Reset asserted mid-cycle from ALARM.
    #3;
    rst = 1'b0;
    #1;
    last_ct = '0;
    push_exp(2'd0, 8'd0, 1'b0, '0, "mid_reset_from_alarm");
    check_pop();
    @(negedge clk);
    rst = 1'b1;
    v.rs = 0; v.sel = 0; v.a = 0; v.b = 0; v.t = 0; v.c = 0; v.v = 0; v.d = G;
    v.st = 2'd0; v.cnt = 8'd0; v.name = "post_reset_idle";
    step(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
